// File: rtl/sdp_xrdma_pkg.sv
// Shared types and helpers for the SDP element RDMA read-request engine.
package sdp_xrdma_pkg;

  typedef enum logic [1:0] {
    XR_IDLE  = 2'd0,
    XR_RUN   = 2'd1,
    XR_DRAIN = 2'd2
  } xrdma_state_e;

  localparam int BLEN_W        = 5;   // holds a burst length of 1..16 atoms
  localparam int CNT_W         = 14;  // holds width+1 up to 8192 atoms
  localparam int LAT_DEPTH_DEF = 128;
  localparam int CDT_W         = $clog2(LAT_DEPTH_DEF + 1);

  function automatic int sel_w(input int num_port);
    return (num_port > 1) ? $clog2(num_port) : 1;
  endfunction

  function automatic int cdt_w(input int lat_depth);
    return $clog2(lat_depth + 1);
  endfunction

  function automatic logic [BLEN_W-1:0] burst_len(input logic [CNT_W-1:0] remaining,
                                                  input int max_burst);
    if (remaining > CNT_W'(max_burst)) return BLEN_W'(max_burst);
    return BLEN_W'(remaining);
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_xrdma_cdt.sv
// Latency-FIFO atom credit pool: debited by accepted bursts, refilled one atom per pop.
module nv_nvdla_sdp_xrdma_cdt
  import sdp_xrdma_pkg::*;
#(
  parameter int LAT_DEPTH = 128,
  parameter int CW        = cdt_w(LAT_DEPTH)
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              accept,
  input  logic [BLEN_W-1:0] accept_n,
  input  logic              pop,
  output logic [CW-1:0]     credit,
  output logic              full
);

  // One spare bit so a pop into a full pool is visible rather than wrapping.
  logic [CW:0] credit_nxt;

  always_comb begin
    credit_nxt = {1'b0, credit};
    if (accept) credit_nxt = credit_nxt - (CW+1)'(accept_n);
    if (pop)    credit_nxt = credit_nxt + (CW+1)'(1);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) credit <= CW'(LAT_DEPTH);
    else                  credit <= credit_nxt[CW-1:0];
  end

  assign full = (credit == CW'(LAT_DEPTH));

  cdt_overflow_a: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    credit_nxt <= (CW+1)'(LAT_DEPTH))
    else $error("xrdma credit pool overflow");

endmodule

// File: rtl/nv_nvdla_sdp_xrdma_req.sv
// SDP element RDMA read-request engine: walks width x height x surface in bursts,
// routes each request to the ram_type port and throttles on latency-FIFO credits.
module nv_nvdla_sdp_xrdma_req
  import sdp_xrdma_pkg::*;
#(
  parameter int AM_AW     = 5,
  parameter int AW        = 64,
  parameter int MAX_BURST = 8,
  parameter int LAT_DEPTH = 128,
  parameter int NUM_PORT  = 2,
  parameter int SEL_W     = sel_w(NUM_PORT)
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                reg2dp_op_en,
  input  logic [31:0]         reg2dp_base_addr_high,
  input  logic [31-AM_AW:0]   reg2dp_base_addr_low,
  input  logic [31-AM_AW:0]   reg2dp_line_stride,
  input  logic [31-AM_AW:0]   reg2dp_surface_stride,
  input  logic [12:0]         reg2dp_width,
  input  logic [12:0]         reg2dp_height,
  input  logic [12:0]         reg2dp_surfaces,
  input  logic [SEL_W-1:0]    reg2dp_ram_type,
  input  logic                reg2dp_perf_dma_en,
  output logic [NUM_PORT-1:0] dma_rd_req_valid,
  input  logic [NUM_PORT-1:0] dma_rd_req_ready,
  output logic [AW-1:0]       dma_rd_req_addr,
  output logic [3:0]          dma_rd_req_size,
  input  logic                dma_rd_cdt_pop,
  output logic                layer_process,
  output logic                dp2reg_done,
  output logic [31:0]         dp2reg_rdma_stall
);

  localparam int LBW = AW - AM_AW;
  localparam int SW  = 32 - AM_AW;
  localparam int CW  = cdt_w(LAT_DEPTH);

  xrdma_state_e      state;
  logic [LBW-1:0]    surf_base, line_base, base_atoms;
  logic [63-AM_AW:0] base_cat;
  logic [SW-1:0]     line_stride_r, surf_stride_r;
  logic [12:0]       width_r, height_r, surfaces_r, h_cnt, s_cnt;
  logic [SEL_W-1:0]  sel_r;
  logic              perf_en_r;
  logic [CNT_W-1:0]  w_cnt, w_next, line_len, remaining;
  logic [BLEN_W-1:0] n_calc, pd_n;
  logic              pd_vld;
  logic [CW-1:0]     credit;
  logic              cdt_full, op_load, req_vld, req_rdy, accept;
  logic              last_in_line, last_burst;

  assign base_cat   = {reg2dp_base_addr_high, reg2dp_base_addr_low};
  assign base_atoms = LBW'(base_cat);
  assign op_load    = reg2dp_op_en & ~layer_process;

  assign line_len     = CNT_W'(width_r) + CNT_W'(1);
  assign remaining    = line_len - w_cnt;
  assign n_calc       = burst_len(remaining, MAX_BURST);
  assign w_next       = w_cnt + CNT_W'(pd_n);
  assign last_in_line = (w_next == line_len);
  assign last_burst   = last_in_line & (h_cnt == height_r) & (s_cnt == surfaces_r);

  // Handshake: the selected valid rises once a computed request (pd_vld) has enough
  // credit; addr/size/port then stay frozen until valid & ready[sel] on a rising edge.
  // Pops only add credit, so valid never falls before the handshake.
  assign req_vld          = pd_vld & (32'(credit) >= 32'(pd_n));
  assign req_rdy          = dma_rd_req_ready[sel_r];
  assign accept           = req_vld & req_rdy;
  assign dma_rd_req_valid = req_vld ? (NUM_PORT'(1) << sel_r) : '0;
  assign dp2reg_done      = (state == XR_DRAIN) & cdt_full;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state           <= XR_IDLE;
      layer_process   <= 1'b0;
      surf_base       <= '0;
      line_base       <= '0;
      line_stride_r   <= '0;
      surf_stride_r   <= '0;
      width_r         <= '0;
      height_r        <= '0;
      surfaces_r      <= '0;
      sel_r           <= '0;
      perf_en_r       <= 1'b0;
      w_cnt           <= '0;
      h_cnt           <= '0;
      s_cnt           <= '0;
      pd_vld          <= 1'b0;
      pd_n            <= '0;
      dma_rd_req_addr <= '0;
      dma_rd_req_size <= '0;
    end else begin
      case (state)
        XR_IDLE: begin
          if (op_load) begin
            state         <= XR_RUN;
            layer_process <= 1'b1;
            surf_base     <= base_atoms;
            line_base     <= base_atoms;
            line_stride_r <= reg2dp_line_stride;
            surf_stride_r <= reg2dp_surface_stride;
            width_r       <= reg2dp_width;
            height_r      <= reg2dp_height;
            surfaces_r    <= reg2dp_surfaces;
            sel_r         <= reg2dp_ram_type;
            perf_en_r     <= reg2dp_perf_dma_en;
            w_cnt         <= '0;
            h_cnt         <= '0;
            s_cnt         <= '0;
            pd_vld        <= 1'b0;
          end
        end
        XR_RUN: begin
          if (!pd_vld) begin
            // Address-compute cycle: the counters settled on the previous edge.
            dma_rd_req_addr <= {line_base + LBW'(w_cnt), {AM_AW{1'b0}}};
            dma_rd_req_size <= 4'(n_calc - BLEN_W'(1));
            pd_n            <= n_calc;
            pd_vld          <= 1'b1;
          end else if (accept) begin
            pd_vld <= 1'b0;
            if (last_in_line) begin
              w_cnt <= '0;
              if (h_cnt == height_r) begin
                h_cnt <= '0;
                if (s_cnt != surfaces_r) begin
                  s_cnt     <= s_cnt + 13'd1;
                  surf_base <= surf_base + LBW'(surf_stride_r);
                  line_base <= surf_base + LBW'(surf_stride_r);
                end
              end else begin
                h_cnt     <= h_cnt + 13'd1;
                line_base <= line_base + LBW'(line_stride_r);
              end
            end else begin
              w_cnt <= w_next;
            end
            if (last_burst) state <= XR_DRAIN;
          end
        end
        XR_DRAIN: begin
          if (cdt_full) begin
            state         <= XR_IDLE;
            layer_process <= 1'b0;
          end
        end
        default: state <= XR_IDLE;
      endcase
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)
      dp2reg_rdma_stall <= '0;
    else if (op_load)
      dp2reg_rdma_stall <= '0;
    else if (perf_en_r && req_vld && !req_rdy && dp2reg_rdma_stall != 32'hFFFF_FFFF)
      dp2reg_rdma_stall <= dp2reg_rdma_stall + 32'd1;
  end

  nv_nvdla_sdp_xrdma_cdt #(.LAT_DEPTH(LAT_DEPTH)) u_cdt (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .accept          (accept),
    .accept_n        (pd_n),
    .pop             (dma_rd_cdt_pop),
    .credit          (credit),
    .full            (cdt_full)
  );

endmodule

// File: tb/tb_nv_nvdla_sdp_xrdma_req.sv
// Bench for nv_nvdla_sdp_xrdma_req: request list from nested-loop address arithmetic,
// atom credit pool modelled as an outstanding-atom count.
module tb_nv_nvdla_sdp_xrdma_req;

  localparam int AM_AW     = 5;
  localparam int AW        = 64;
  localparam int MAX_BURST = 8;
  localparam int LAT_DEPTH = 16;
  localparam int NUM_PORT  = 4;
  localparam int SEL_W     = 2;

  logic                nvdla_core_clk, nvdla_core_rstn;
  logic                reg2dp_op_en, reg2dp_perf_dma_en, dma_rd_cdt_pop;
  logic [31:0]         reg2dp_base_addr_high;
  logic [31-AM_AW:0]   reg2dp_base_addr_low, reg2dp_line_stride, reg2dp_surface_stride;
  logic [12:0]         reg2dp_width, reg2dp_height, reg2dp_surfaces;
  logic [SEL_W-1:0]    reg2dp_ram_type;
  logic [NUM_PORT-1:0] dma_rd_req_valid, dma_rd_req_ready;
  logic [AW-1:0]       dma_rd_req_addr;
  logic [3:0]          dma_rd_req_size;
  logic                layer_process, dp2reg_done;
  logic [31:0]         dp2reg_rdma_stall;

  nv_nvdla_sdp_xrdma_req #(
    .AM_AW(AM_AW), .AW(AW), .MAX_BURST(MAX_BURST), .LAT_DEPTH(LAT_DEPTH),
    .NUM_PORT(NUM_PORT), .SEL_W(SEL_W)
  ) dut (
    .nvdla_core_clk        (nvdla_core_clk),
    .nvdla_core_rstn       (nvdla_core_rstn),
    .reg2dp_op_en          (reg2dp_op_en),
    .reg2dp_base_addr_high (reg2dp_base_addr_high),
    .reg2dp_base_addr_low  (reg2dp_base_addr_low),
    .reg2dp_line_stride    (reg2dp_line_stride),
    .reg2dp_surface_stride (reg2dp_surface_stride),
    .reg2dp_width          (reg2dp_width),
    .reg2dp_height         (reg2dp_height),
    .reg2dp_surfaces       (reg2dp_surfaces),
    .reg2dp_ram_type       (reg2dp_ram_type),
    .reg2dp_perf_dma_en    (reg2dp_perf_dma_en),
    .dma_rd_req_valid      (dma_rd_req_valid),
    .dma_rd_req_ready      (dma_rd_req_ready),
    .dma_rd_req_addr       (dma_rd_req_addr),
    .dma_rd_req_size       (dma_rd_req_size),
    .dma_rd_cdt_pop        (dma_rd_cdt_pop),
    .layer_process         (layer_process),
    .dp2reg_done           (dp2reg_done),
    .dp2reg_rdma_stall     (dp2reg_rdma_stall)
  );

  int checks = 0;
  int errors = 0;
  logic [AW+3:0] exp_q[$];
  int outstanding, acc_cnt, lstep, first_vld, done_step, last_pop_step, stall_exp;
  int rdy_mode, pop_mode, pop_budget, hold_cnt;
  bit done_seen, prev_pend;
  logic [AW-1:0] prev_addr;
  logic [3:0]    prev_size;

  initial begin
    nvdla_core_clk = 1'b0;
    forever #5 nvdla_core_clk = ~nvdla_core_clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Every burst of the cube, in issue order, from plain offset arithmetic.
  task automatic build_exp();
    logic [63:0]   atom;
    logic [AW-1:0] a;
    int n, wid;
    wid = int'(reg2dp_width);
    for (int s = 0; s <= int'(reg2dp_surfaces); s++)
      for (int h = 0; h <= int'(reg2dp_height); h++)
        for (int w = 0; w <= wid; w += n) begin
          n = (wid + 1 - w > MAX_BURST) ? MAX_BURST : wid + 1 - w;
          atom = {5'b0, reg2dp_base_addr_high, reg2dp_base_addr_low}
               + 64'(s) * 64'(reg2dp_surface_stride)
               + 64'(h) * 64'(reg2dp_line_stride) + 64'(w);
          a = {atom[63-AM_AW:0], {AM_AW{1'b0}}};
          exp_q.push_back({a, 4'(n - 1)});
        end
  endtask

  task automatic step();
    logic [NUM_PORT-1:0] v;
    logic [AW+3:0] e;
    logic hs, pop;
    int sel, n;
    @(negedge nvdla_core_clk);
    lstep++;
    sel = int'(reg2dp_ram_type);
    v   = dma_rd_req_valid;
    n   = int'(dma_rd_req_size) + 1;
    case (rdy_mode)
      0: dma_rd_req_ready = '1;
      1: dma_rd_req_ready = NUM_PORT'($urandom_range(0, 15));
      default: begin
        dma_rd_req_ready = '1;
        if (v[sel] && hold_cnt > 0) begin
          dma_rd_req_ready[sel] = 1'b0;
          hold_cnt--;
        end
      end
    endcase
    pop = 1'b0;
    if (outstanding > 0)
      case (pop_mode)
        1: pop = 1'b1;
        2: pop = ($urandom_range(0, 1) == 1);
        3: if (pop_budget > 0) begin pop = 1'b1; pop_budget--; end
        default: pop = 1'b0;
      endcase
    dma_rd_cdt_pop = pop;
    if (dp2reg_done && !done_seen) begin
      done_seen = 1'b1;
      done_step = lstep;
      check("done_drained", 64'(outstanding), 64'd0);
    end
    if (v != '0) begin
      if (first_vld < 0) first_vld = lstep;
      check("vld_port", 64'(v), 64'd1 << sel);
      check("vld_credit", 64'(LAT_DEPTH - outstanding >= n), 64'd1);
    end
    if (prev_pend) begin
      check("vld_hold", 64'(v[sel]), 64'd1);
      check("addr_hold", dma_rd_req_addr, prev_addr);
      check("size_hold", 64'(dma_rd_req_size), 64'(prev_size));
    end
    hs = v[sel] & dma_rd_req_ready[sel];
    if (v[sel] && !dma_rd_req_ready[sel] && reg2dp_perf_dma_en) stall_exp++;
    if (hs) begin
      acc_cnt++;
      outstanding += n;
      check("req_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("req_addr", dma_rd_req_addr, e[AW+3:4]);
        check("req_size", 64'(dma_rd_req_size), 64'(e[3:0]));
      end
    end
    prev_pend = v[sel] && !hs;
    prev_addr = dma_rd_req_addr;
    prev_size = dma_rd_req_size;
    if (pop) begin
      outstanding--;
      last_pop_step = lstep;
    end
  endtask

  task automatic do_reset();
    nvdla_core_rstn = 1'b0;
    reg2dp_op_en    = 1'b0;
    dma_rd_cdt_pop  = 1'b0;
    #1;
    check("rst_valid", 64'(dma_rd_req_valid), 64'd0);
    check("rst_addr", dma_rd_req_addr, 64'd0);
    check("rst_size", 64'(dma_rd_req_size), 64'd0);
    check("rst_lp", 64'(layer_process), 64'd0);
    check("rst_done", 64'(dp2reg_done), 64'd0);
    check("rst_stall", 64'(dp2reg_rdma_stall), 64'd0);
    repeat (2) @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b1;
    exp_q.delete();
    outstanding = 0;
    prev_pend   = 1'b0;
  endtask

  task automatic start_layer();
    lstep         = 0;
    first_vld     = -1;
    done_seen     = 1'b0;
    stall_exp     = 0;
    acc_cnt       = 0;
    prev_pend     = 1'b0;
    last_pop_step = -100;
    reg2dp_op_en  = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget, input int exp_first);
    int k = 0;
    while (!done_seen && k < budget) begin
      step();
      k++;
    end
    check({tag, ":done"}, 64'(done_seen), 64'd1);
    check({tag, ":left"}, 64'(exp_q.size()), 64'd0);
    check({tag, ":first_vld"}, 64'(first_vld), 64'(exp_first));
    check({tag, ":done_lat"}, 64'(done_step - last_pop_step), 64'd1);
    check({tag, ":stall"}, 64'(dp2reg_rdma_stall), 64'(stall_exp));
    if (!done_seen) do_reset();
  endtask

  task automatic end_layer(input string tag);
    reg2dp_op_en = 1'b0;
    step();
    check({tag, ":lp_clr"}, 64'(layer_process), 64'd0);
    check({tag, ":done_pulse"}, 64'(dp2reg_done), 64'd0);
  endtask

  task automatic set_cube(input logic [31:0] bh, input logic [31-AM_AW:0] bl,
                          input logic [31-AM_AW:0] ls, input logic [31-AM_AW:0] ss,
                          input logic [12:0] w, input logic [12:0] h, input logic [12:0] s);
    reg2dp_base_addr_high = bh;
    reg2dp_base_addr_low  = bl;
    reg2dp_line_stride    = ls;
    reg2dp_surface_stride = ss;
    reg2dp_width          = w;
    reg2dp_height         = h;
    reg2dp_surfaces       = s;
  endtask

  initial begin
    nvdla_core_rstn    = 1'b0;
    reg2dp_op_en       = 1'b0;
    reg2dp_perf_dma_en = 1'b0;
    reg2dp_ram_type    = '0;
    dma_rd_req_ready   = '0;
    dma_rd_cdt_pop     = 1'b0;
    rdy_mode = 0; pop_mode = 1; pop_budget = 0; hold_cnt = 0;
    outstanding = 0; prev_pend = 1'b0;
    set_cube(32'h0, '0, '0, '0, '0, '0, '0);
    repeat (2) @(negedge nvdla_core_clk);
    do_reset();

    // Single line split 8/8/4 atoms.
    set_cube(32'h0, 27'h80, 27'h0, 27'h0, 13'd19, 13'd0, 13'd0);
    build_exp(); start_layer();
    wait_done("line20", 200, 2);
    end_layer("line20");

    // One-atom lines across two surfaces.
    set_cube(32'h0, 27'h0, 27'd4, 27'h100, 13'd0, 13'd2, 13'd1);
    build_exp(); start_layer();
    wait_done("w0", 200, 2);
    end_layer("w0");

    // Credit starvation: two bursts fill the pool; one pop is not enough, eight are.
    pop_mode = 3; pop_budget = 0;
    set_cube(32'h0, 27'h40, 27'h0, 27'h0, 13'd31, 13'd0, 13'd0);
    build_exp(); start_layer();
    repeat (20) step();
    check("starve:acc2", 64'(acc_cnt), 64'd2);
    check("starve:vld_low", 64'(dma_rd_req_valid), 64'd0);
    pop_budget = 1;
    repeat (10) step();
    check("starve:acc_after1", 64'(acc_cnt), 64'd2);
    check("starve:vld_low1", 64'(dma_rd_req_valid), 64'd0);
    pop_budget = 7;
    repeat (10) step();
    check("starve:acc_after8", 64'(acc_cnt), 64'd3);
    pop_mode = 1;
    wait_done("starve", 400, 2);
    end_layer("starve");

    // Port 2 held not-ready for five valid cycles.
    reg2dp_ram_type = 2'd2; reg2dp_perf_dma_en = 1'b1; rdy_mode = 2; hold_cnt = 5;
    set_cube(32'h1, 27'h12345, 27'h0, 27'h0, 13'd0, 13'd0, 13'd0);
    build_exp(); start_layer();
    wait_done("stall", 200, 2);
    check("stall:count5", 64'(dp2reg_rdma_stall), 64'd5);
    end_layer("stall");
    check("stall:hold_after_done", 64'(dp2reg_rdma_stall), 64'd5);
    rdy_mode = 0; reg2dp_perf_dma_en = 1'b0; reg2dp_ram_type = '0;

    // Reset with 13 atoms in flight (credit 3), then a layer needing the full pool.
    pop_mode = 0;
    set_cube(32'h0, 27'h10, 27'h0, 27'h0, 13'd12, 13'd0, 13'd0);
    build_exp(); start_layer();
    for (int k = 0; k < 30 && acc_cnt < 2; k++) step();
    check("rstrun:acc2", 64'(acc_cnt), 64'd2);
    do_reset();
    set_cube(32'h0, 27'h20, 27'h0, 27'h0, 13'd15, 13'd0, 13'd0);
    build_exp(); start_layer();
    repeat (12) step();
    check("rstrun:full_pool", 64'(acc_cnt), 64'd2);
    pop_mode = 1;
    wait_done("rstrun", 200, 2);
    end_layer("rstrun");

    // Top-of-memory base: second atom wraps to 0; op_en held for a back-to-back layer.
    set_cube(32'hFFFF_FFFF, 27'h7FF_FFFF, 27'h0, 27'h0, 13'd1, 13'd0, 13'd0);
    build_exp(); start_layer();
    wait_done("wrap", 200, 2);
    build_exp(); start_layer();
    step();
    check("keep:lp_gap", 64'(layer_process), 64'd0);
    step();
    check("keep:lp_again", 64'(layer_process), 64'd1);
    wait_done("keep", 200, 3);
    end_layer("keep");

    // Line stride carries the address past 2^64.
    set_cube(32'hFFFF_FFFF, 27'h7FF_FFFF, 27'd2, 27'h0, 13'd3, 13'd1, 13'd0);
    build_exp(); start_layer();
    wait_done("wrapline", 200, 2);
    end_layer("wrapline");

    // Random cubes, random ready and random credit return.
    rdy_mode = 1; pop_mode = 2;
    for (int t = 0; t < 6; t++) begin
      reg2dp_ram_type    = SEL_W'($urandom_range(0, 3));
      reg2dp_perf_dma_en = 1'($urandom_range(0, 1));
      set_cube($urandom, 27'($urandom), 27'($urandom_range(0, 1 << 20)),
               27'($urandom_range(0, 1 << 22)), 13'($urandom_range(0, 40)),
               13'($urandom_range(0, 3)), 13'($urandom_range(0, 2)));
      build_exp(); start_layer();
      wait_done("rand", 20000, 2);
      end_layer("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
